// File: rtl/wb_stage.sv
// Writeback stage: formats retiring results (ALU, load, link) and queues them in a
// small in-order FIFO that drains into the register file under rf_ready_i backpressure.
module wb_stage #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int RADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [1:0]               wb_sel_i,
  input  logic                     reg_write_i,
  input  logic [RADDR_W-1:0]       rd_addr_i,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic [XLEN-1:0]          mem_read_data_i,
  input  logic [1:0]               load_size_i,
  input  logic                     load_unsigned_i,
  input  logic [2:0]               addr_lo_i,
  input  logic [XLEN-1:0]          pc_i,
  output logic                     rf_we_o,
  output logic [RADDR_W-1:0]       rf_waddr_o,
  output logic [XLEN-1:0]          rf_wdata_o,
  input  logic                     rf_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_LINK = 2'd2,
    SEL_NONE = 2'd3
  } wb_sel_e;

  wb_sel_e              w_sel;
  logic [2:0]           w_lane_mask;
  logic [2:0]           w_off;
  logic [5:0]           w_shamt;
  logic [XLEN-1:0]      w_shifted;
  logic [XLEN-1:0]      w_word_ext;
  logic [XLEN-1:0]      w_load_data;
  logic [XLEN-1:0]      w_result;
  logic                 w_entry_we;

  assign w_sel = wb_sel_e'(wb_sel_i);

  // Lane mask keeps only the address bits that select a lane of the requested size.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_lane_mask = 3'b000;
    case (load_size_i)
      2'd0:    w_lane_mask = (XLEN == 64) ? 3'b111 : 3'b011;
      2'd1:    w_lane_mask = (XLEN == 64) ? 3'b110 : 3'b010;
      2'd2:    w_lane_mask = (XLEN == 64) ? 3'b100 : 3'b000;
      default: w_lane_mask = 3'b000;
    endcase
  end

  assign w_off     = addr_lo_i & w_lane_mask;
  assign w_shamt   = {w_off, 3'b000};
  assign w_shifted = mem_read_data_i >> w_shamt;

  generate
    if (XLEN == 64) begin : g_word_ext
      assign w_word_ext = {{32{~load_unsigned_i & w_shifted[31]}}, w_shifted[31:0]};
    end else begin : g_word_pass
      assign w_word_ext = w_shifted;
    end
  endgenerate

  always_comb begin
    w_load_data = w_shifted;
    case (load_size_i)
      2'd0:    w_load_data = {{(XLEN-8){~load_unsigned_i & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load_data = {{(XLEN-16){~load_unsigned_i & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_load_data = w_word_ext;
      default: w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (w_sel)
      SEL_ALU:  w_result = alu_result_i;
      SEL_MEM:  w_result = w_load_data;
      SEL_LINK: w_result = pc_i + XLEN'(4);
      default:  w_result = '0;
    endcase
  end

  assign w_entry_we = reg_write_i && (w_sel != SEL_NONE) && (rd_addr_i != '0);

  logic [XLEN-1:0]    r_data [DEPTH];
  logic [RADDR_W-1:0] r_addr [DEPTH];
  logic               r_we_flag [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_empty;
  logic w_head_we;
  logic w_push;
  logic w_pop;

  assign w_empty    = (r_count == '0);
  assign w_head_we  = r_we_flag[r_rd_ptr];
  assign in_ready_o = (r_count < CNT_W'(DEPTH));
  assign w_push     = in_valid_i & in_ready_o;
  assign rf_we_o    = ~w_empty & w_head_we;
  assign w_pop      = ~w_empty & (~w_head_we | rf_ready_i);
  assign rf_waddr_o = w_empty ? '0 : r_addr[r_rd_ptr];
  assign rf_wdata_o = w_empty ? '0 : r_data[r_rd_ptr];
  assign count_o    = r_count;

  // NOTE: entry storage has no reset; validity is carried solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr]    <= w_result;
      r_addr[r_wr_ptr]    <= rd_addr_i;
      r_we_flag[r_wr_ptr] <= w_entry_we;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load/link formatting tables on XLEN=32 and XLEN=64
// instances, plus backpressure, full-queue and mid-operation reset sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [63:0] alu_result;
  logic [63:0] mem_data;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic [2:0]  addr_lo;
  logic [63:0] pc;
  logic        rf_ready;

  logic        rdy32, we32;
  logic [4:0]  waddr32;
  logic [31:0] wdata32;
  logic [1:0]  cnt32;
  logic        rdy64, we64;
  logic [4:0]  waddr64;
  logic [63:0] wdata64;
  logic [1:0]  cnt64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .DEPTH(2), .RADDR_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .wb_sel_i(wb_sel), .reg_write_i(reg_write), .rd_addr_i(rd_addr),
    .alu_result_i(alu_result[31:0]), .mem_read_data_i(mem_data[31:0]),
    .load_size_i(load_size), .load_unsigned_i(load_unsigned), .addr_lo_i(addr_lo),
    .pc_i(pc[31:0]), .rf_we_o(we32), .rf_waddr_o(waddr32), .rf_wdata_o(wdata32),
    .rf_ready_i(rf_ready), .count_o(cnt32)
  );

  wb_stage #(.XLEN(64), .DEPTH(2), .RADDR_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .wb_sel_i(wb_sel), .reg_write_i(reg_write), .rd_addr_i(rd_addr),
    .alu_result_i(alu_result), .mem_read_data_i(mem_data),
    .load_size_i(load_size), .load_unsigned_i(load_unsigned), .addr_lo_i(addr_lo),
    .pc_i(pc), .rf_we_o(we64), .rf_waddr_o(waddr64), .rf_wdata_o(wdata64),
    .rf_ready_i(rf_ready), .count_o(cnt64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          x64;
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  lo;
    logic [63:0] pc;
    logic        exp_we;
    logic [63:0] exp_data;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic drive(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] mem, input logic [1:0] size,
                       input logic uns, input logic [2:0] lo, input logic [63:0] pcv);
    wb_sel = sel; reg_write = rw; rd_addr = rd; alu_result = alu; mem_data = mem;
    load_size = size; load_unsigned = uns; addr_lo = lo; pc = pcv; in_valid = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic       we;
    logic [4:0] wa;
    logic [63:0] wd;
    logic [1:0] cnt;
    drive(v.sel, v.rw, v.rd, v.alu, v.mem, v.size, v.uns, v.lo, v.pc);
    @(negedge clk);
    in_valid = 1'b0;
    we  = v.x64 ? we64    : we32;
    wa  = v.x64 ? waddr64 : waddr32;
    wd  = v.x64 ? wdata64 : {32'h0, wdata32};
    cnt = v.x64 ? cnt64   : cnt32;
    check($sformatf("v%0d_we", idx), {63'h0, we}, {63'h0, v.exp_we});
    check($sformatf("v%0d_cnt1", idx), {62'h0, cnt}, 64'd1);
    if (v.exp_we) begin
      check($sformatf("v%0d_waddr", idx), {59'h0, wa}, {59'h0, v.rd});
      check($sformatf("v%0d_wdata", idx), wd, v.exp_data);
    end
    @(negedge clk);
    cnt = v.x64 ? cnt64 : cnt32;
    check($sformatf("v%0d_cnt0", idx), {62'h0, cnt}, 64'd0);
  endtask

  initial begin
    // {x64, sel, rw, rd, alu, mem, size, uns, lo, pc, exp_we, exp_data}
    vecs[0]  = '{0, 2'd1, 1, 5'd5,  64'h0, 64'h12345680, 2'd0, 0, 3'd0, 64'h0, 1, 64'hFFFFFF80};
    vecs[1]  = '{0, 2'd1, 1, 5'd6,  64'h0, 64'h12345680, 2'd0, 1, 3'd0, 64'h0, 1, 64'h00000080};
    vecs[2]  = '{0, 2'd1, 1, 5'd7,  64'h0, 64'h12345680, 2'd0, 0, 3'd3, 64'h0, 1, 64'h00000012};
    vecs[3]  = '{0, 2'd1, 1, 5'd8,  64'h0, 64'h80017FFF, 2'd1, 0, 3'd2, 64'h0, 1, 64'hFFFF8001};
    vecs[4]  = '{0, 2'd1, 1, 5'd9,  64'h0, 64'h80017FFF, 2'd1, 1, 3'd2, 64'h0, 1, 64'h00008001};
    vecs[5]  = '{0, 2'd1, 1, 5'd10, 64'h0, 64'h80017FFF, 2'd1, 0, 3'd1, 64'h0, 1, 64'h00007FFF};
    vecs[6]  = '{0, 2'd1, 1, 5'd11, 64'h0, 64'hDEADBEEF, 2'd2, 0, 3'd0, 64'h0, 1, 64'hDEADBEEF};
    vecs[7]  = '{0, 2'd0, 1, 5'd31, 64'h12345678, 64'h0, 2'd0, 0, 3'd0, 64'h0, 1, 64'h12345678};
    vecs[8]  = '{0, 2'd2, 1, 5'd1,  64'h0, 64'h0, 2'd0, 0, 3'd0, 64'hFFFFFFFC, 1, 64'h00000000};
    vecs[9]  = '{0, 2'd2, 1, 5'd2,  64'h0, 64'h0, 2'd0, 0, 3'd0, 64'h00001000, 1, 64'h00001004};
    vecs[10] = '{0, 2'd0, 1, 5'd0,  64'h55, 64'h0, 2'd0, 0, 3'd0, 64'h0, 0, 64'h0};
    vecs[11] = '{0, 2'd3, 1, 5'd3,  64'h55, 64'h0, 2'd0, 0, 3'd0, 64'h0, 0, 64'h0};
    vecs[12] = '{0, 2'd0, 0, 5'd4,  64'h55, 64'h0, 2'd0, 0, 3'd0, 64'h0, 0, 64'h0};
    vecs[13] = '{0, 2'd1, 1, 5'd12, 64'h0, 64'h80000001, 2'd3, 0, 3'd4, 64'h0, 1, 64'h80000001};
    vecs[14] = '{0, 2'd1, 1, 5'd13, 64'h0, 64'h12345680, 2'd0, 0, 3'd5, 64'h0, 1, 64'h00000056};
    vecs[15] = '{1, 2'd1, 1, 5'd14, 64'h0, 64'h8001000000000000, 2'd1, 1, 3'd6, 64'h0, 1, 64'h0000000000008001};
    vecs[16] = '{1, 2'd1, 1, 5'd15, 64'h0, 64'h8001000000000000, 2'd1, 0, 3'd6, 64'h0, 1, 64'hFFFFFFFFFFFF8001};
    vecs[17] = '{1, 2'd1, 1, 5'd16, 64'h0, 64'h8000000012345678, 2'd2, 0, 3'd4, 64'h0, 1, 64'hFFFFFFFF80000000};
    vecs[18] = '{1, 2'd1, 1, 5'd17, 64'h0, 64'h8000000012345678, 2'd2, 1, 3'd0, 64'h0, 1, 64'h0000000012345678};
    vecs[19] = '{1, 2'd1, 1, 5'd18, 64'h0, 64'h8000000012345678, 2'd0, 0, 3'd7, 64'h0, 1, 64'hFFFFFFFFFFFFFF80};
    vecs[20] = '{1, 2'd1, 1, 5'd19, 64'h0, 64'h8000000012345678, 2'd3, 0, 3'd0, 64'h0, 1, 64'h8000000012345678};
    vecs[21] = '{1, 2'd2, 1, 5'd20, 64'h0, 64'h0, 2'd0, 0, 3'd0, 64'hFFFFFFFFFFFFFFFC, 1, 64'h0};
    vecs[22] = '{1, 2'd2, 1, 5'd21, 64'h0, 64'h0, 2'd0, 0, 3'd0, 64'h00000000FFFFFFFC, 1, 64'h0000000100000000};

    rst = 1'b1; in_valid = 1'b0; rf_ready = 1'b1;
    wb_sel = 2'd0; reg_write = 1'b0; rd_addr = '0; alu_result = '0; mem_data = '0;
    load_size = 2'd0; load_unsigned = 1'b0; addr_lo = 3'd0; pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cnt32", {62'h0, cnt32}, 64'd0);
    check("rst_we32", {63'h0, we32}, 64'd0);
    check("rst_rdy32", {63'h0, rdy32}, 64'd1);
    check("rst_waddr32", {59'h0, waddr32}, 64'd0);
    check("rst_wdata32", {32'h0, wdata32}, 64'd0);
    check("rst_cnt64", {62'h0, cnt64}, 64'd0);

    for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

    // Backpressure: two accepted, third held off until a slot frees.
    rf_ready = 1'b0;
    drive(2'd0, 1'b1, 5'd1, 64'h11, 64'h0, 2'd0, 1'b0, 3'd0, 64'h0);
    check("bp_rdy_a", {63'h0, rdy32}, 64'd1);
    @(negedge clk);
    drive(2'd0, 1'b1, 5'd2, 64'h22, 64'h0, 2'd0, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    drive(2'd0, 1'b1, 5'd3, 64'h33, 64'h0, 2'd0, 1'b0, 3'd0, 64'h0);
    check("bp_full_rdy", {63'h0, rdy32}, 64'd0);
    check("bp_full_cnt", {62'h0, cnt32}, 64'd2);
    check("bp_full_we", {63'h0, we32}, 64'd1);
    check("bp_head_addr", {59'h0, waddr32}, 64'd1);
    check("bp_head_data", {32'h0, wdata32}, 64'h11);
    @(negedge clk);
    check("bp_hold_cnt", {62'h0, cnt32}, 64'd2);
    check("bp_hold_addr", {59'h0, waddr32}, 64'd1);
    check("bp_hold_data", {32'h0, wdata32}, 64'h11);
    rf_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1_cnt", {62'h0, cnt32}, 64'd1);
    check("bp_pop1_addr", {59'h0, waddr32}, 64'd2);
    check("bp_pop1_data", {32'h0, wdata32}, 64'h22);
    check("bp_pop1_rdy", {63'h0, rdy32}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_pushpop_cnt", {62'h0, cnt32}, 64'd1);
    check("bp_pushpop_addr", {59'h0, waddr32}, 64'd3);
    check("bp_pushpop_data", {32'h0, wdata32}, 64'h33);
    @(negedge clk);
    check("bp_drain_cnt", {62'h0, cnt32}, 64'd0);
    check("bp_drain_we", {63'h0, we32}, 64'd0);

    // Reset with a full queue discards both writes.
    rf_ready = 1'b0;
    drive(2'd0, 1'b1, 5'd6, 64'h66, 64'h0, 2'd0, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    drive(2'd0, 1'b1, 5'd7, 64'h77, 64'h0, 2'd0, 1'b0, 3'd0, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_pre_cnt", {62'h0, cnt32}, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_cnt", {62'h0, cnt32}, 64'd0);
    check("mr_we", {63'h0, we32}, 64'd0);
    check("mr_rdy", {63'h0, rdy32}, 64'd1);
    check("mr_waddr", {59'h0, waddr32}, 64'd0);
    check("mr_wdata", {32'h0, wdata32}, 64'd0);
    rf_ready = 1'b1;
    @(negedge clk);
    check("mr_after_we", {63'h0, we32}, 64'd0);
    check("mr_after_cnt", {62'h0, cnt32}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, writeback queue entries; power of two, >=2.
REQ-003 Parameter RADDR_W, default 5, register address width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid_i  in  1  upstream offers a retiring instruction.
REQ-007 in_ready_o  out  1  block accepts the offer this cycle.
REQ-008 wb_sel_i  in  2  result source: 0 ALU, 1 memory load, 2 link (pc_i+4), 3 none.
REQ-009 reg_write_i  in  1  instruction writes a register.
REQ-010 rd_addr_i  in  RADDR_W  destination register.
REQ-011 alu_result_i  in  XLEN  ALU result.
REQ-012 mem_read_data_i  in  XLEN  raw, naturally aligned memory word.
REQ-013 load_size_i  in  2  0 byte, 1 half, 2 word, 3 dword.
REQ-014 load_unsigned_i  in  1  zero-extend rather than sign-extend.
REQ-015 addr_lo_i  in  3  low load address bits.
REQ-016 pc_i  in  XLEN  instruction PC.
REQ-017 rf_we_o  out  1  register-file write strobe.
REQ-018 rf_waddr_o  out  RADDR_W  write address.
REQ-019 rf_wdata_o  out  XLEN  write data.
REQ-020 rf_ready_i  in  1  register file accepts the write this cycle.
REQ-021 count_o  out  clog2(DEPTH)+1  queue occupancy.

Function
REQ-022 Accept (push) occurs when in_valid_i and in_ready_o are both high; in_ready_o = (count_o < DEPTH), independent of rf_ready_i in the same cycle.
REQ-023 On push, formatted result and control are written to the queue tail; rf_* reflect the head one cycle later at the earliest (latency 1).
REQ-024 Load formatting: byte lane = addr_lo_i (XLEN 64) or addr_lo_i[1:0] (XLEN 32); half lane = addr_lo_i[2:1]/[1]; word lane = addr_lo_i[2] (XLEN 64) or lane 0; unused low bits ignored.
REQ-025 Selected field is sign-extended to XLEN from its MSB unless load_unsigned_i, then zero-extended; dword, or size 3 when XLEN=32 (treated as word), passes unmodified.
REQ-026 Link result = pc_i + 4, modulo 2^XLEN.
REQ-027 Entry write flag = reg_write_i AND wb_sel_i != 3 AND rd_addr_i != 0.
REQ-028 rf_we_o = queue non-empty AND head write flag; rf_waddr_o/rf_wdata_o = head fields when non-empty, else 0.
REQ-029 Pop when (rf_we_o AND rf_ready_i) OR (non-empty AND head write flag 0); write-flag-0 entries retire in one cycle without rf_we_o.
REQ-030 Simultaneous push and pop: count unchanged, both pointers advance; permitted whenever in_ready_o high.
REQ-031 Full: in_ready_o low; offers ignored; queue contents unchanged; a pop in that cycle does not admit an offer until the next cycle.
REQ-032 Pointers wrap modulo DEPTH; entries retire strictly in push order.
REQ-033 While rf_we_o high and rf_ready_i low, rf_* held stable.

Reset
REQ-034 While rst high at a clock edge: pointers and count_o cleared to 0, all entries discarded, rf_we_o/rf_waddr_o/rf_wdata_o 0, in_ready_o 1 from the next cycle.
REQ-035 Reset mid-operation discards queued writes; no rf_we_o pulse in the cycle following reset.

Verification
REQ-036 XLEN=32, push LB, mem 0x12345680, addr_lo 0, signed -> rf_wdata_o 0xFFFFFF80, rd as given, next cycle.
REQ-037 XLEN=64, LHU, mem 0x8001_0000_0000_0000, addr_lo 6 -> rf_wdata_o 0x0000_0000_0000_8001.
REQ-038 rf_ready_i held 0, DEPTH=2, three offers -> two accepted, in_ready_o 0, count_o 2; release -> writes retire in order, third accepted only after a slot frees.
REQ-039 Push with rd_addr_i=0 or wb_sel_i=3 -> no rf_we_o, count_o returns to 0 one cycle after push.
REQ-040 JAL link, pc_i 0xFFFFFFFC, XLEN=32 -> rf_wdata_o 0x00000000.
REQ-041 rst asserted with count_o 2 -> count_o 0, rf_we_o 0 next cycle, in_ready_o 1.
